// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mips_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] ID_LD = 2'd0;
    localparam logic [1:0] ID_DM = 2'd1;
    localparam logic [1:0] ID_IF = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mips_mem_prio_sel.sv
// Fixed-priority selector LD > DM > IF; a starving fetch jumps ahead of DM but never LD.
module mips_mem_prio_sel
    import mips_mem_pkg::*;
(
    input  logic       ld_req_i,
    input  logic       dm_req_i,
    input  logic       if_req_i,
    input  logic       starve_i,
    output logic [2:0] gnt_o,
    output logic [1:0] id_o
);

    always_comb begin
        gnt_o = '0;
        id_o  = ID_LD;
        if (ld_req_i) begin
            gnt_o = 3'b001;
            id_o  = ID_LD;
        end else if (if_req_i && starve_i) begin
            gnt_o = 3'b100;
            id_o  = ID_IF;
        end else if (dm_req_i) begin
            gnt_o = 3'b010;
            id_o  = ID_DM;
        end else if (if_req_i) begin
            gnt_o = 3'b100;
            id_o  = ID_IF;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises loader, data-stage and fetch accesses onto one single-port memory,
// one outstanding transaction at a time, with tagged responses.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              resp_valid,
    output logic [1:0]        resp_id,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WCW = $clog2(MEM_LATENCY + 1);
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MEM_LATENCY - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    state_e            state_q;
    logic [WCW-1:0]    wait_cnt_q;
    logic [SCW-1:0]    starve_q, starve_d;
    logic              we_q;
    logic [1:0]        id_q;
    logic              resp_valid_q, busy_q, mem_en_q, mem_we_q;
    logic [1:0]        resp_id_q;
    logic [DATA_W-1:0] resp_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              arb_en, starve_hit;
    logic [2:0]        sel_gnt, gnt;
    logic [1:0]        sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign arb_en     = (state_q == IDLE) || (state_q == RESP);
    assign starve_hit = (starve_q >= STARVE_MAX);

    mips_mem_prio_sel u_prio (
        .ld_req_i (ld_req),
        .dm_req_i (dm_req),
        .if_req_i (if_req),
        .starve_i (starve_hit),
        .gnt_o    (sel_gnt),
        .id_o     (sel_id)
    );

    assign gnt    = arb_en ? sel_gnt : '0;
    assign ld_gnt = gnt[0];
    assign dm_gnt = gnt[1];
    assign if_gnt = gnt[2];

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = '0;
        case (sel_id)
            ID_LD: begin
                sel_we    = ld_we;
                sel_addr  = ld_addr;
                sel_wdata = ld_wdata;
            end
            ID_DM: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = if_addr;
                sel_wdata = '0;
            end
        endcase
    end

    // Fetch starvation counts every denied cycle, including while a transaction is in flight.
    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (if_req && !starve_hit) begin
            starve_d = starve_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_q     <= '0;
            we_q         <= 1'b0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_rdata_q <= '0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            resp_valid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (|gnt) begin
                        state_q     <= ISSUE;
                        we_q        <= sel_we;
                        id_q        <= sel_id;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                    busy_q     <= 1'b1;
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_rdata_q <= we_q ? '0 : mem_rdata;
                        busy_q       <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_rdata = resp_rdata_q;
    assign busy       = busy_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, issue slots and
// tagged responses; a separate monitor pops and compares them as the DUT presents them.
module tb_mips_mem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int SL   = 4;
    localparam int LAT3 = 3;

    typedef struct {
        int              due;
        logic [1:0]      id;
        logic [DW-1:0]   data;
    } resp_t;

    typedef struct {
        int              due;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } issue_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ld_req, ld_we, dm_req, dm_we, if_req;
    logic [AW-1:0] ld_addr, dm_addr, if_addr;
    logic [DW-1:0] ld_wdata, dm_wdata;
    logic          ld_gnt, dm_gnt, if_gnt;
    logic          resp_valid, busy, mem_en, mem_we;
    logic [1:0]    resp_id;
    logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          ld3_req, ld3_we, ld3_gnt, dm3_gnt, if3_gnt;
    logic [AW-1:0] ld3_addr, mem3_addr;
    logic [DW-1:0] ld3_wdata, resp3_rdata, mem3_wdata, mem3_rdata;
    logic          resp3_valid, busy3, mem3_en, mem3_we;
    logic [1:0]    resp3_id;

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT3), .STARVE_LIMIT(SL)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld3_req), .ld_we(ld3_we), .ld_addr(ld3_addr), .ld_wdata(ld3_wdata), .ld_gnt(ld3_gnt),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0), .dm_gnt(dm3_gnt),
        .if_req(1'b0), .if_addr('0), .if_gnt(if3_gnt),
        .resp_valid(resp3_valid), .resp_id(resp3_id), .resp_rdata(resp3_rdata), .busy(busy3),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned i);
        if (i == 5) return 32'h0022_2000;
        return (i * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(0, 1023));
    endfunction

    // Memories with a read pipeline of the configured latency.
    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] pipe [LAT];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        pipe[0] <= mem[mem_addr];
        end
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    logic [DW-1:0] mem3  [1024];
    logic [DW-1:0] pipe3 [LAT3];
    logic          mem3_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem3_ready) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= init_word(i);
            mem3_ready <= 1'b1;
        end else if (mem3_en) begin
            if (mem3_we) mem3[mem3_addr] <= mem3_wdata;
            else         pipe3[0] <= mem3[mem3_addr];
        end
        for (int k = 1; k < LAT3; k++) pipe3[k] <= pipe3[k-1];
    end
    assign mem3_rdata = pipe3[LAT3-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    resp_t  rq[$];
    issue_t iq[$];
    logic [DW-1:0] ref_mem [1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one access per 2+LAT cycles, priority with fetch starvation override.
    initial begin : model
        int starve, next_free, last_gnt, w;
        logic [2:0] eg;
        resp_t r;
        issue_t is;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        starve = 0; next_free = 0; last_gnt = -100;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rq.delete(); iq.delete();
                starve = 0; next_free = cyc + 1; last_gnt = -100;
            end else begin
                w = -1;
                if (cyc >= next_free) begin
                    if (ld_req)                      w = 0;
                    else if (if_req && starve >= SL) w = 2;
                    else if (dm_req)                 w = 1;
                    else if (if_req)                 w = 2;
                end
                eg = (w == 0) ? 3'b001 : (w == 1) ? 3'b010 : (w == 2) ? 3'b100 : 3'b000;
                chk("grant", 32'({if_gnt, dm_gnt, ld_gnt}), 32'(eg));
                chk("busy", 32'(busy), 32'(cyc > last_gnt && cyc <= last_gnt + 1 + LAT));
                if (w >= 0) begin
                    is.due = cyc + 1;
                    case (w)
                        0:       begin is.we = ld_we; is.addr = ld_addr; is.wdata = ld_wdata; end
                        1:       begin is.we = dm_we; is.addr = dm_addr; is.wdata = dm_wdata; end
                        default: begin is.we = 1'b0;  is.addr = if_addr; is.wdata = '0;       end
                    endcase
                    r.due = cyc + 2 + LAT;
                    r.id  = 2'(w);
                    if (is.we) begin
                        ref_mem[is.addr] = is.wdata;
                        r.data = '0;
                    end else begin
                        r.data = ref_mem[is.addr];
                    end
                    iq.push_back(is);
                    rq.push_back(r);
                    last_gnt  = cyc;
                    next_free = cyc + 2 + LAT;
                end
                if (w == 2)                     starve = 0;
                else if (if_req && starve < SL) starve++;
            end
        end
    end

    initial begin : monitor
        resp_t r;
        issue_t is;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (resp_valid) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", 32'(resp_valid), 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("resp_cycle", 32'(cyc), 32'(r.due));
                        chk("resp_id", 32'(resp_id), 32'(r.id));
                        chk("resp_rdata", resp_rdata, r.data);
                    end
                end
                while (rq.size() > 0 && rq[0].due < cyc) begin
                    r = rq.pop_front();
                    chk("resp_missing", 32'(0), 32'(r.due));
                end
                if (mem_en) begin
                    if (iq.size() == 0) begin
                        chk("mem_en_unexpected", 32'(mem_en), 32'd0);
                    end else begin
                        is = iq.pop_front();
                        chk("issue_cycle", 32'(cyc), 32'(is.due));
                        chk("mem_we", 32'(mem_we), 32'(is.we));
                        chk("mem_addr", 32'(mem_addr), 32'(is.addr));
                        if (is.we) chk("mem_wdata", mem_wdata, is.wdata);
                    end
                end
                while (iq.size() > 0 && iq[0].due < cyc) begin
                    is = iq.pop_front();
                    chk("issue_missing", 32'(0), 32'(is.due));
                end
            end
        end
    end

    task automatic step(output logic [2:0] g);
        @(negedge clk);
        g = {if_gnt, dm_gnt, ld_gnt};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [2:0] g;
        repeat (n) step(g);
    endtask

    task automatic run_pending();
        logic [2:0] g;
        int k;
        k = 0;
        while ((ld_req || dm_req || if_req) && k < 100) begin
            step(g);
            if (g[0]) ld_req = 1'b0;
            if (g[1]) dm_req = 1'b0;
            if (g[2]) if_req = 1'b0;
            k++;
        end
        if (k >= 100) begin
            chk("grant_timeout", 32'(k), 32'd0);
            ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [2:0] g;
        logic got;
        rst_n = 1'b0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req = 0; if_addr = '0;
        ld3_req = 0; ld3_we = 0; ld3_addr = '0; ld3_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        if_req = 1; if_addr = 10'd5;
        run_pending();
        idle(4);

        dm_req = 1; dm_we = 1; dm_addr = 10'h3FF; dm_wdata = 32'hDEAD_BEEF;
        run_pending();
        if_req = 1; if_addr = 10'h3FF;
        run_pending();
        idle(4);

        ld_req = 1; ld_we = 0; ld_addr = 10'd7;
        dm_req = 1; dm_we = 0; dm_addr = 10'd8;
        if_req = 1; if_addr = 10'd9;
        run_pending();
        idle(4);

        dm_req = 1; dm_we = 0; dm_addr = 10'd10;
        if_req = 1; if_addr = 10'd11;
        for (int t = 0; t < 12; t++) begin
            step(g);
            chk("starve_pattern", 32'(g),
                (t == 0 || t == 3 || t == 9) ? 32'b010 : (t == 6) ? 32'b100 : 32'b000);
        end
        dm_req = 0; if_req = 0;
        idle(4);

        // Reset during WAIT of a DM read must drop the access silently.
        dm_req = 1; dm_we = 0; dm_addr = 10'd5;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = dm_gnt;
        end
        chk("rst_test_gnt", 32'(got), 32'd1);
        @(posedge clk); #1 dm_req = 0;
        @(posedge clk); #1;
        chk("rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);

        for (int t = 0; t < 3000; t++) begin
            step(g);
            if (ld_req && !g[0]) begin
                if ($urandom_range(0, 15) == 0) ld_req = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                ld_req = 1; ld_we = 1'($urandom_range(0, 1));
                ld_addr = rand_addr(); ld_wdata = $urandom;
            end else begin
                ld_req = 0;
            end
            if (dm_req && !g[1]) begin
                if ($urandom_range(0, 15) == 0) dm_req = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = rand_addr(); dm_wdata = $urandom;
            end else begin
                dm_req = 0;
            end
            if (if_req && !g[2]) begin
                if ($urandom_range(0, 15) == 0) if_req = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                if_req = 1; if_addr = rand_addr();
            end else begin
                if_req = 0;
            end
        end
        ld_req = 0; dm_req = 0; if_req = 0;
        idle(10);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
        chk("issue_queue_drained", 32'(iq.size()), 32'd0);

        ld3_req = 1; ld3_we = 0; ld3_addr = AW'($urandom_range(0, 1023));
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = ld3_gnt;
        end
        chk("lat3_gnt", 32'(got), 32'd1);
        @(posedge clk); #1 ld3_req = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("lat3_busy", 32'(busy3), 32'(k <= 4));
            chk("lat3_resp_valid", 32'(resp3_valid), 32'(k == 5));
            if (k == 5) begin
                chk("lat3_resp_id", 32'(resp3_id), 32'd0);
                chk("lat3_resp_rdata", resp3_rdata, init_word(32'(ld3_addr)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
